// File: rtl/data_memory_lsu_if.sv
// Request/response bus between the core and the data memory LSU.
// The master issues one request at a time; the slave answers with a one-cycle pulse.
interface data_memory_lsu_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_lsu.sv
// RV32I byte-addressed data memory with load/store unit and wait states.
// Misaligned/illegal accesses respond with rsp_err and never write the RAM.
module data_memory_lsu #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  data_memory_lsu_if.slave bus
);
  localparam int WORDS = 1 << (ADDR_W - 2);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [WORDS];

  logic              accept;
  logic              commit;
  logic              c_we;
  logic [2:0]        c_f3;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [1:0]        lane;
  logic [ADDR_W-3:0] idx;
  logic              err;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic [31:0]       word;
  logic [31:0]       shw;
  logic [15:0]       half;
  logic [31:0]       ld;

  assign accept = bus.req_valid && bus.req_ready;

  // With zero wait states the access commits on the accept edge itself.
  always_comb begin
    if (state == IDLE) begin
      c_we    = bus.req_we;
      c_f3    = bus.req_funct3;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
    end else begin
      c_we    = we_q;
      c_f3    = f3_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
    end
  end

  assign commit = (state == IDLE && accept && LATENCY == 0)
               || (state == WAIT && cnt == 3'd1);

  assign lane = c_addr[1:0];
  assign idx  = c_addr[ADDR_W-1:2];
  assign word = mem[idx];
  assign shw  = word >> {lane, 3'b000};
  assign half = c_addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    err = 1'b0;
    unique case (c_f3)
      3'd0, 3'd4: err = 1'b0;
      3'd1, 3'd5: err = c_addr[0];
      3'd2:       err = |c_addr[1:0];
      default:    err = 1'b1;
    endcase
    if (c_we && (c_f3 == 3'd4 || c_f3 == 3'd5)) err = 1'b1;
  end

  always_comb begin
    be = 4'b0000;
    wd = c_wdata;
    unique case (1'b1)
      c_f3 == 3'd0: begin
        be = 4'b0001 << lane;
        wd = {4{c_wdata[7:0]}};
      end
      c_f3 == 3'd1: begin
        be = c_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{c_wdata[15:0]}};
      end
      c_f3 == 3'd2: be = 4'b1111;
      default:      be = 4'b0000;
    endcase
  end

  always_comb begin
    ld = '0;
    unique case (1'b1)
      c_f3 == 3'd0: ld = {{24{shw[7]}}, shw[7:0]};
      c_f3 == 3'd1: ld = {{16{half[15]}}, half};
      c_f3 == 3'd2: ld = word;
      c_f3 == 3'd4: ld = {24'd0, shw[7:0]};
      c_f3 == 3'd5: ld = {16'd0, half};
      default:      ld = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && c_we && !err && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      f3_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        state         <= RESP;
        cnt           <= '0;
        bus.req_ready <= 1'b0;
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= err;
        bus.rsp_rdata <= (err || c_we) ? '0 : ld;
      end else begin
        unique case (state)
          IDLE: if (accept) begin
            state         <= WAIT;
            cnt           <= 3'(LATENCY);
            bus.req_ready <= 1'b0;
          end
          WAIT: cnt <= cnt - 3'd1;
          RESP: begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu: vector table on LATENCY=1,
// plus reset-abort (LATENCY=3) and throughput runs (LATENCY=0 and 7).
module tb_data_memory_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst3 = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_memory_lsu_if b0 ();
  data_memory_lsu_if b1 ();
  data_memory_lsu_if b3 ();
  data_memory_lsu_if b7 ();

  data_memory_lsu #(.LATENCY(0)) u0 (.clk(clk), .rst(rst),  .bus(b0.slave));
  data_memory_lsu #(.LATENCY(1)) u1 (.clk(clk), .rst(rst),  .bus(b1.slave));
  data_memory_lsu #(.LATENCY(3)) u3 (.clk(clk), .rst(rst3), .bus(b3.slave));
  data_memory_lsu #(.LATENCY(7)) u7 (.clk(clk), .rst(rst),  .bus(b7.slave));

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(int w, logic v, logic we, logic [2:0] f3,
                       logic [15:0] a, logic [31:0] d);
    case (w)
      0: begin b0.req_valid = v; b0.req_we = we; b0.req_funct3 = f3;
               b0.req_addr = a; b0.req_wdata = d; end
      1: begin b1.req_valid = v; b1.req_we = we; b1.req_funct3 = f3;
               b1.req_addr = a; b1.req_wdata = d; end
      3: begin b3.req_valid = v; b3.req_we = we; b3.req_funct3 = f3;
               b3.req_addr = a; b3.req_wdata = d; end
      default: begin b7.req_valid = v; b7.req_we = we; b7.req_funct3 = f3;
               b7.req_addr = a; b7.req_wdata = d; end
    endcase
  endtask

  function automatic logic rdy(int w);
    case (w)
      0: return b0.req_ready;
      1: return b1.req_ready;
      3: return b3.req_ready;
      default: return b7.req_ready;
    endcase
  endfunction

  function automatic logic rv(int w);
    case (w)
      0: return b0.rsp_valid;
      1: return b1.rsp_valid;
      3: return b3.rsp_valid;
      default: return b7.rsp_valid;
    endcase
  endfunction

  function automatic logic [32:0] rsp(int w);
    case (w)
      0: return {b0.rsp_err, b0.rsp_rdata};
      1: return {b1.rsp_err, b1.rsp_rdata};
      3: return {b3.rsp_err, b3.rsp_rdata};
      default: return {b7.rsp_err, b7.rsp_rdata};
    endcase
  endfunction

  // One request; lat counts cycles from the accept cycle to the response cycle.
  task automatic run_req(int w, logic we, logic [2:0] f3, logic [15:0] a,
                         logic [31:0] d, output logic [31:0] rd,
                         output logic er, output int lat,
                         output logic rdy_after, output logic one_pulse);
    int n;
    logic [32:0] r;
    @(negedge clk);
    drive(w, 1'b1, we, f3, a, d);
    n = 0;
    while (!rdy(w) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    drive(w, 1'b0, ~we, 3'd3, 16'hFFFF, 32'hFFFF_FFFF);
    rdy_after = rdy(w);
    lat = 1;
    while (!rv(w) && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r  = rsp(w);
    rd = r[31:0];
    er = r[32];
    @(posedge clk);
    #1;
    one_pulse = !rv(w) && rdy(w);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        ra;
    logic        op;
    int          lat;
    int          n0, n7, l0, l7, g0, g7, stray;

    vecs.push_back('{1'b1, 3'd2, 16'h0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 16'h0013, 32'h0000_0080, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 16'h0013, 32'h0,        32'hFFFF_FF80, 1'b0});
    vecs.push_back('{1'b0, 3'd4, 16'h0013, 32'h0,        32'h0000_0080, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 16'h0010, 32'h0,        32'h80AD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 3'd1, 16'h0012, 32'h0000_1234, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 16'h0010, 32'h0,        32'h1234_BEEF, 1'b0});
    vecs.push_back('{1'b0, 3'd1, 16'h0012, 32'h0,        32'h0000_1234, 1'b0});
    vecs.push_back('{1'b1, 3'd1, 16'h0010, 32'h0000_F00D, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd1, 16'h0010, 32'h0,        32'hFFFF_F00D, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 16'h0011, 32'h0,        32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd1, 16'h0013, 32'h0000_AAAA, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd2, 16'h0010, 32'h0,        32'h1234_F00D, 1'b0});
    vecs.push_back('{1'b0, 3'd3, 16'h0010, 32'h0,        32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd5, 16'h0012, 32'h0,        32'h0000_1234, 1'b0});
    vecs.push_back('{1'b0, 3'd5, 16'h0010, 32'h0,        32'h0000_F00D, 1'b0});
    vecs.push_back('{1'b0, 3'd4, 16'h0011, 32'h0,        32'h0000_00F0, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 16'h0011, 32'h0,        32'hFFFF_FFF0, 1'b0});
    vecs.push_back('{1'b1, 3'd2, 16'h0014, 32'h0000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 16'h0015, 32'hABCD_EF7F, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 16'h0014, 32'h0,        32'h0000_7F00, 1'b0});
    vecs.push_back('{1'b1, 3'd1, 16'h0016, 32'h9999_8001, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 16'h0014, 32'h0,        32'h8001_7F00, 1'b0});
    vecs.push_back('{1'b0, 3'd1, 16'h0016, 32'h0,        32'hFFFF_8001, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 16'h0012, 32'h0,        32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd6, 16'h0014, 32'h0,        32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd7, 16'h0014, 32'h1111_1111, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd4, 16'h0014, 32'h2222_2222, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd5, 16'h0014, 32'h3333_3333, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd2, 16'h0014, 32'h0,        32'h8001_7F00, 1'b0});

    for (int w = 0; w < 8; w++) drive(w, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(b1.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(b1.rsp_valid), 32'd0);
    chk("reset rsp_rdata", b1.rsp_rdata, 32'd0);
    chk("reset rsp_err",   32'(b1.rsp_err), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    rst3 = 1'b0;

    // Vector table on LATENCY=1
    foreach (vecs[i]) begin
      run_req(1, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
              rd, er, lat, ra, op);
      chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d latency", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d ready_busy", i), 32'(ra), 32'd0);
      chk($sformatf("v%0d one_pulse", i), 32'(op), 32'd1);
    end

    // Reset during a pending store on LATENCY=3
    run_req(3, 1'b1, 3'd2, 16'h0020, 32'h1111_2222, rd, er, lat, ra, op);
    chk("l3 sw latency", 32'(lat), 32'd4);
    @(negedge clk);
    drive(3, 1'b1, 1'b1, 3'd2, 16'h0020, 32'h5555_AAAA);
    @(posedge clk);
    #1;
    drive(3, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0);
    chk("l3 busy after accept", 32'(b3.req_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst3 = 1'b1;
    #1;
    chk("l3 ready in reset", 32'(b3.req_ready), 32'd1);
    stray = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (b3.rsp_valid || !b3.req_ready) stray++;
    end
    @(negedge clk);
    rst3 = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (b3.rsp_valid) stray++;
    end
    chk("l3 no rsp after reset", 32'(stray), 32'd0);
    run_req(3, 1'b0, 3'd2, 16'h0020, 32'h0, rd, er, lat, ra, op);
    chk("l3 old value kept", rd, 32'h1111_2222);
    chk("l3 lw latency", 32'(lat), 32'd4);

    // Throughput with req_valid held high: LATENCY=0 and 7
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 3'd2, 16'h0040, 32'hCAFE_F00D);
    drive(7, 1'b1, 1'b1, 3'd2, 16'h0044, 32'h1234_5678);
    n0 = 0; n7 = 0; l0 = -1; l7 = -1; g0 = 0; g7 = 0;
    for (int i = 0; i < 20; i++) begin
      if (b0.req_ready) begin
        if (l0 >= 0 && i - l0 != 2) g0++;
        l0 = i;
        n0++;
      end
      if (b7.req_ready) begin
        if (l7 >= 0 && i - l7 != 9) g7++;
        l7 = i;
        n7++;
      end
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0);
    drive(7, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0);
    chk("l0 accept count", 32'(n0), 32'd10);
    chk("l0 accept spacing", 32'(g0), 32'd0);
    chk("l7 accept count", 32'(n7), 32'd3);
    chk("l7 accept spacing", 32'(g7), 32'd0);
    repeat (12) @(posedge clk);

    run_req(0, 1'b0, 3'd2, 16'h0040, 32'h0, rd, er, lat, ra, op);
    chk("l0 lw data", rd, 32'hCAFE_F00D);
    chk("l0 lw latency", 32'(lat), 32'd1);
    chk("l0 one_pulse", 32'(op), 32'd1);
    run_req(0, 1'b0, 3'd1, 16'h0041, 32'h0, rd, er, lat, ra, op);
    chk("l0 lh misaligned err", 32'(er), 32'd1);
    run_req(7, 1'b0, 3'd2, 16'h0044, 32'h0, rd, er, lat, ra, op);
    chk("l7 lw data", rd, 32'h1234_5678);
    chk("l7 lw latency", 32'(lat), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
